multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// Latency: j 2, beq 3, R-type/ori/lui 4, sw 4+w, lw 5+w cycles (w = mem_ready=0 cycles in MEM).
// Backpressure: MEM holds while mem_ready=0; nothing else stalls.
// Ports: clock/reset (async active-low); ins, zero, mem_ready in; PC/IR/reg/mem write strobes,
//        datapath selects, ALUctr, state, retire/illegal pulses and icount out.
module multicycle_ctrl #(
    parameter int ICNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ins,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              PCWr,
    output logic              IRWr,
    output logic              RegWr,
    output logic              MemWr,
    output logic              nPC_sel,
    output logic              jumpCtr,
    output logic              RegDst,
    output logic              ExtOp,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic [2:0]        ALUctr,
    output logic [2:0]        state,
    output logic              retire,
    output logic              illegal,
    output logic [ICNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    state_t state_q;
    state_t state_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_legal;

    assign op    = ins[31:26];
    assign funct = ins[5:0];

    assign is_addu  = (op == 6'b000000) && (funct == 6'b100001);
    assign is_subu  = (op == 6'b000000) && (funct == 6'b100011);
    assign is_ori   = (op == 6'b001101);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_lui   = (op == 6'b001111);
    assign is_j     = (op == 6'b000010);
    assign is_legal = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_lui | is_j;

    // Raw (ungated) strobes from the FSM; reset masks them below.
    logic pcwr_c, irwr_c, regwr_c, memwr_c, npc_c, jump_c, retire_c, illegal_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        pcwr_c    = 1'b0;
        irwr_c    = 1'b0;
        regwr_c   = 1'b0;
        memwr_c   = 1'b0;
        npc_c     = 1'b0;
        jump_c    = 1'b0;
        retire_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwr_c  = 1'b1;
                pcwr_c  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pcwr_c   = 1'b1;
                    jump_c   = 1'b1;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (!is_legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pcwr_c   = zero;
                    npc_c    = zero;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = S_WB;
                end else begin
                    // ins changed under us to something not executable here: restart.
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                memwr_c = is_sw;
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (is_lw) begin
                    state_d = S_WB;
                end else begin
                    retire_c = is_sw;
                    state_d  = S_FETCH;
                end
            end
            S_WB: begin
                regwr_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWr    = reset & pcwr_c;
    assign IRWr    = reset & irwr_c;
    assign RegWr   = reset & regwr_c;
    assign MemWr   = reset & memwr_c;
    assign nPC_sel = reset & npc_c;
    assign jumpCtr = reset & jump_c;
    assign retire  = reset & retire_c;
    assign illegal = reset & illegal_c;
    assign state   = state_q;

    // Datapath selects follow ins only in the post-fetch states; zero in FETCH and unused codes.
    logic sel_en;
    assign sel_en = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

    always_comb begin
        ExtOp    = 1'b0;
        ALUSrc   = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUctr   = ALU_ADD;
        if (sel_en) begin
            ExtOp    = is_lw | is_sw | is_beq;
            ALUSrc   = is_ori | is_lui | is_lw | is_sw;
            RegDst   = is_addu | is_subu;
            MemtoReg = is_lw;
            if (is_subu || is_beq) ALUctr = ALU_SUB;
            else if (is_ori)       ALUctr = ALU_OR;
            else if (is_lui)       ALUctr = ALU_LUI;
            else                   ALUctr = ALU_ADD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            icount <= '0;
        end else if (retire_c) begin
            icount <= icount + ICNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic        zero;
    logic        mem_ready;
    logic        PCWr, IRWr, RegWr, MemWr, nPC_sel, jumpCtr;
    logic        RegDst, ExtOp, ALUSrc, MemtoReg;
    logic [2:0]  ALUctr;
    logic [2:0]  state;
    logic        retire, illegal;
    logic [31:0] icount;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADDU = 32'h0000_0021;
    localparam logic [31:0] I_SUBU = 32'h0000_0023;
    localparam logic [31:0] I_ORI  = 32'h3400_0000;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_LUI  = 32'h3C00_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_BADF = 32'h0000_0000;

    multicycle_ctrl #(.ICNT_W(32)) dut (
        .clock(clock), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .nPC_sel(nPC_sel), .jumpCtr(jumpCtr), .RegDst(RegDst), .ExtOp(ExtOp),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUctr(ALUctr), .state(state),
        .retire(retire), .illegal(illegal), .icount(icount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ins = I_ADDU; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        n_tests++;
        if (state !== 3'd0 || icount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d icount=%0d, want 0 0", state, icount);
        end
        n_tests++;
        if ({PCWr, IRWr, RegWr, MemWr, retire, illegal} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: %b, want 000000", {PCWr, IRWr, RegWr, MemWr, retire, illegal});
        end
        reset = 1'b1;
        #1;
    endtask

    // ins chosen by caller; runs F,D,E,WB and checks per-cycle behaviour.
    task automatic run_alu(input logic [31:0] i, input logic [2:0] exp_alu,
                           input logic exp_src, input logic exp_dst, input logic [31:0] exp_cnt,
                           input string name);
        logic [2:0] exp_state [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        ins = i;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (state !== exp_state[c] || RegWr !== (c == 3) || retire !== (c == 3) ||
                MemWr !== 1'b0 || IRWr !== (c == 0)) begin
                n_fail++;
                $display("FAIL %s_cyc%0d: state=%0d RegWr=%b retire=%b MemWr=%b IRWr=%b, want state=%0d RegWr=%b retire=%b MemWr=0 IRWr=%b",
                         name, c, state, RegWr, retire, MemWr, IRWr, exp_state[c], c == 3, c == 3, c == 0);
            end
            if (c == 0) begin
                n_tests++;
                if ({RegDst, ALUSrc, ALUctr} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL %s_fetch_sel: %b, want 00000", name, {RegDst, ALUSrc, ALUctr});
                end
            end
            if (c == 3) begin
                n_tests++;
                if (ALUctr !== exp_alu || ALUSrc !== exp_src || RegDst !== exp_dst || MemtoReg !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_sel: ALUctr=%b ALUSrc=%b RegDst=%b MemtoReg=%b, want %b %b %b 0",
                             name, ALUctr, ALUSrc, RegDst, MemtoReg, exp_alu, exp_src, exp_dst);
                end
            end
            tick();
        end
        n_tests++;
        if (state !== 3'd0 || icount !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_done: state=%0d icount=%0d, want 0 %0d", name, state, icount, exp_cnt);
        end
    endtask

    task automatic test_addu();
        run_alu(I_ADDU, 3'b000, 1'b0, 1'b1, 32'd1, "addu");
    endtask

    task automatic test_lw();
        logic [2:0] exp_state [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        ins = I_LW;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            n_tests++;
            if (state !== exp_state[c] || MemWr !== 1'b0 || retire !== (c == 7) || RegWr !== (c == 7)) begin
                n_fail++;
                $display("FAIL lw_cyc%0d: state=%0d MemWr=%b retire=%b RegWr=%b, want state=%0d MemWr=0 retire=%b RegWr=%b",
                         c, state, MemWr, retire, RegWr, exp_state[c], c == 7, c == 7);
            end
            if (c == 7) begin
                n_tests++;
                if (MemtoReg !== 1'b1 || ExtOp !== 1'b1 || ALUSrc !== 1'b1 || RegDst !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lw_wb_sel: MemtoReg=%b ExtOp=%b ALUSrc=%b RegDst=%b, want 1 1 1 0",
                             MemtoReg, ExtOp, ALUSrc, RegDst);
                end
            end
            tick();
        end
        mem_ready = 1'b1;
        n_tests++;
        if (state !== 3'd0 || icount !== 32'd2) begin
            n_fail++;
            $display("FAIL lw_done: state=%0d icount=%0d, want 0 2", state, icount);
        end
    endtask

    task automatic test_sw();
        logic [2:0] exp_state [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        ins = I_SW; mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (state !== exp_state[c] || MemWr !== (c == 3) || RegWr !== 1'b0 || retire !== (c == 3)) begin
                n_fail++;
                $display("FAIL sw_cyc%0d: state=%0d MemWr=%b RegWr=%b retire=%b, want state=%0d MemWr=%b RegWr=0 retire=%b",
                         c, state, MemWr, RegWr, retire, exp_state[c], c == 3, c == 3);
            end
            if (c == 2) begin
                n_tests++;
                if (ExtOp !== 1'b1 || ALUSrc !== 1'b1 || ALUctr !== 3'b000) begin
                    n_fail++;
                    $display("FAIL sw_sel: ExtOp=%b ALUSrc=%b ALUctr=%b, want 1 1 000", ExtOp, ALUSrc, ALUctr);
                end
            end
            tick();
        end
        n_tests++;
        if (state !== 3'd0 || icount !== 32'd3) begin
            n_fail++;
            $display("FAIL sw_done: state=%0d icount=%0d, want 0 3", state, icount);
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            ins = I_BEQ;
            zero = (k == 0);
            for (int c = 0; c < 3; c++) begin
                #1;
                n_tests++;
                if (state !== c[2:0] || retire !== (c == 2) ||
                    PCWr !== ((c == 0) || (c == 2 && k == 0)) || nPC_sel !== (c == 2 && k == 0)) begin
                    n_fail++;
                    $display("FAIL beq%0d_cyc%0d: state=%0d PCWr=%b nPC_sel=%b retire=%b, want state=%0d PCWr=%b nPC_sel=%b retire=%b",
                             k, c, state, PCWr, nPC_sel, retire, c, (c == 0) || (c == 2 && k == 0),
                             c == 2 && k == 0, c == 2);
                end
                if (c == 2) begin
                    n_tests++;
                    if (ALUctr !== 3'b001 || ExtOp !== 1'b1 || ALUSrc !== 1'b0) begin
                        n_fail++;
                        $display("FAIL beq%0d_sel: ALUctr=%b ExtOp=%b ALUSrc=%b, want 001 1 0", k, ALUctr, ExtOp, ALUSrc);
                    end
                end
                tick();
            end
        end
        zero = 1'b0;
        n_tests++;
        if (state !== 3'd0 || icount !== 32'd5) begin
            n_fail++;
            $display("FAIL beq_done: state=%0d icount=%0d, want 0 5", state, icount);
        end
    endtask

    task automatic test_j_illegal();
        ins = I_J;
        tick();
        n_tests++;
        if (state !== 3'd1 || PCWr !== 1'b1 || jumpCtr !== 1'b1 || retire !== 1'b1 || nPC_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL j_decode: state=%0d PCWr=%b jumpCtr=%b retire=%b nPC_sel=%b, want 1 1 1 1 0",
                     state, PCWr, jumpCtr, retire, nPC_sel);
        end
        tick();
        n_tests++;
        if (state !== 3'd0 || icount !== 32'd6 || jumpCtr !== 1'b0) begin
            n_fail++;
            $display("FAIL j_done: state=%0d icount=%0d jumpCtr=%b, want 0 6 0", state, icount, jumpCtr);
        end
        for (int k = 0; k < 2; k++) begin
            ins = (k == 0) ? I_BAD : I_BADF;
            tick();
            n_tests++;
            if (state !== 3'd1 || illegal !== 1'b1 || retire !== 1'b0 || PCWr !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_decode: state=%0d illegal=%b retire=%b PCWr=%b, want 1 1 0 0",
                         k, state, illegal, retire, PCWr);
            end
            tick();
            n_tests++;
            if (state !== 3'd0 || illegal !== 1'b0 || icount !== 32'd6) begin
                n_fail++;
                $display("FAIL illegal%0d_done: state=%0d illegal=%b icount=%0d, want 0 0 6",
                         k, state, illegal, icount);
            end
        end
    endtask

    task automatic test_decode_mix();
        run_alu(I_SUBU, 3'b001, 1'b0, 1'b1, 32'd7, "subu");
        run_alu(I_ORI,  3'b010, 1'b1, 1'b0, 32'd8, "ori");
        run_alu(I_LUI,  3'b011, 1'b1, 1'b0, 32'd9, "lui");
    endtask

    task automatic test_reset_mid_mem();
        ins = I_SW; mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        n_tests++;
        if (state !== 3'd3 || MemWr !== 1'b1) begin
            n_fail++;
            $display("FAIL midmem_wait: state=%0d MemWr=%b, want 3 1", state, MemWr);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (state !== 3'd0 || MemWr !== 1'b0 || icount !== 32'd0 || IRWr !== 1'b0 || PCWr !== 1'b0) begin
            n_fail++;
            $display("FAIL midmem_reset: state=%0d MemWr=%b icount=%0d IRWr=%b PCWr=%b, want 0 0 0 0 0",
                     state, MemWr, icount, IRWr, PCWr);
        end
        tick();
        reset = 1'b1; mem_ready = 1'b1; ins = I_ADDU;
        #1;
        n_tests++;
        if (state !== 3'd0 || IRWr !== 1'b1 || PCWr !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_fetch: state=%0d IRWr=%b PCWr=%b, want 0 1 1", state, IRWr, PCWr);
        end
        tick();
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_decode: state=%0d, want 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw();
        test_sw();
        test_beq();
        test_j_illegal();
        test_decode_mix();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
